alu_cmd_encoder: RTL and testbench

ALU_CMD_ENCODER -- requirements
Module: alu_cmd_encoder

---
 rtl/alu_pkg.sv | 33 +++
 rtl/alu_cmd_encoder_onehot_opcode_enc.sv | 30 +++
 rtl/alu_cmd_encoder.sv | 137 +++++++++++++
 tb/tb_alu_cmd_encoder.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared constants for the ALU command encoder: one-hot command bit
// positions, their single-bit masks, and the encoded ALU opcodes.
package alu_pkg;

    localparam int OH_W  = 6;
    localparam int OPC_W = 5;
    localparam int SH_W  = 5;

    // Bit positions of each command inside the one-hot request vector
    localparam int IDX_ADD = 0;
    localparam int IDX_SUB = 1;
    localparam int IDX_AND = 2;
    localparam int IDX_OR  = 3;
    localparam int IDX_SLL = 4;
    localparam int IDX_SRA = 5;

    // Single-bit masks matching the positions above
    localparam logic [OH_W-1:0] OH_ADD = 6'b000001;
    localparam logic [OH_W-1:0] OH_SUB = 6'b000010;
    localparam logic [OH_W-1:0] OH_AND = 6'b000100;
    localparam logic [OH_W-1:0] OH_OR  = 6'b001000;
    localparam logic [OH_W-1:0] OH_SLL = 6'b010000;
    localparam logic [OH_W-1:0] OH_SRA = 6'b100000;

    // Encoded opcodes presented to the ALU
    localparam logic [OPC_W-1:0] OPC_ADD = 5'b00000;
    localparam logic [OPC_W-1:0] OPC_SUB = 5'b00001;
    localparam logic [OPC_W-1:0] OPC_AND = 5'b00010;
    localparam logic [OPC_W-1:0] OPC_OR  = 5'b00011;
    localparam logic [OPC_W-1:0] OPC_SLL = 5'b00100;
    localparam logic [OPC_W-1:0] OPC_SRA = 5'b00101;

endpackage

// File: rtl/alu_cmd_encoder_onehot_opcode_enc.sv
// Combinational one-hot to opcode encoder. A vector is legal only when
// exactly one bit is set; any other pattern reports illegal and drives
// a harmless ADD opcode that the caller never stores.
module onehot_opcode_enc
    import alu_pkg::*;
(
    input  logic [OH_W-1:0]  i_onehot,
    output logic [OPC_W-1:0] o_opcode,
    output logic             o_legal
);

    // Map each single-bit pattern to its opcode; everything else is illegal
    always_comb begin
        o_opcode = OPC_ADD;
        o_legal  = 1'b0;
        case (i_onehot)
            OH_ADD: begin o_opcode = OPC_ADD; o_legal = 1'b1; end
            OH_SUB: begin o_opcode = OPC_SUB; o_legal = 1'b1; end
            OH_AND: begin o_opcode = OPC_AND; o_legal = 1'b1; end
            OH_OR:  begin o_opcode = OPC_OR;  o_legal = 1'b1; end
            OH_SLL: begin o_opcode = OPC_SLL; o_legal = 1'b1; end
            OH_SRA: begin o_opcode = OPC_SRA; o_legal = 1'b1; end
            default: begin
                o_opcode = OPC_ADD;
                o_legal  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_cmd_encoder.sv
// ALU command encoder: accepts one-hot commands with operands, encodes
// them and queues them in a small FIFO in front of the ALU. Illegal
// commands are swallowed and flagged with a one-cycle err_illegal pulse.
// Handshake outputs are registered, so there is no combinational path
// from the request side to the ALU side.
// Optional feature: define ALU_CMD_ENC_ERRCNT_EN to add err_count, a
// saturating 8-bit count of illegal commands.
module alu_cmd_encoder
    import alu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2
)
(
    input  logic              clock,
    input  logic              resetn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [OH_W-1:0]   req_onehot,
    input  logic [DATA_W-1:0] req_a,
    input  logic [DATA_W-1:0] req_b,
    input  logic [SH_W-1:0]   req_shamt,
    output logic              alu_valid,
    input  logic              alu_ready,
    output logic [OPC_W-1:0]  alu_opcode,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [SH_W-1:0]   alu_shamt,
`ifdef ALU_CMD_ENC_ERRCNT_EN
    output logic [7:0]        err_count,
`endif
    output logic              err_illegal
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [OPC_W-1:0]  w_opcode;
    logic              w_legal;
    logic              w_accept;
    logic              w_push;
    logic              w_pop;
    logic [CNT_W-1:0]  w_count_nxt;

    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_req_ready;
    logic              r_alu_valid;
    logic              r_err_illegal;

    // Entry storage carries no reset: occupancy alone says what is valid
    logic [OPC_W-1:0]  r_mem_opcode [DEPTH];
    logic [DATA_W-1:0] r_mem_a      [DEPTH];
    logic [DATA_W-1:0] r_mem_b      [DEPTH];
    logic [SH_W-1:0]   r_mem_shamt  [DEPTH];

    onehot_opcode_enc u_enc (
        .i_onehot (req_onehot),
        .o_opcode (w_opcode),
        .o_legal  (w_legal)
    );

    assign w_accept = req_valid && r_req_ready;
    assign w_push   = w_accept && w_legal;
    assign w_pop    = r_alu_valid && alu_ready;

    // Next occupancy: push and pop together leave it unchanged
    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + CNT_ONE;
            2'b01:   w_count_nxt = r_count - CNT_ONE;
            default: w_count_nxt = r_count;
        endcase
    end

    // Pointers, occupancy and the registered handshake/error flags
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr      <= {PTR_W{1'b0}};
            r_rd_ptr      <= {PTR_W{1'b0}};
            r_count       <= {CNT_W{1'b0}};
            r_req_ready   <= 1'b1;
            r_alu_valid   <= 1'b0;
            r_err_illegal <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            r_count       <= w_count_nxt;
            r_req_ready   <= (w_count_nxt < CNT_FULL);
            r_alu_valid   <= (w_count_nxt != {CNT_W{1'b0}});
            r_err_illegal <= w_accept && !w_legal;
        end
    end

    // Write the encoded command and its operands at the tail
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem_opcode[r_wr_ptr] <= w_opcode;
            r_mem_a[r_wr_ptr]      <= req_a;
            r_mem_b[r_wr_ptr]      <= req_b;
            r_mem_shamt[r_wr_ptr]  <= req_shamt;
        end
    end

    assign req_ready   = r_req_ready;
    assign alu_valid   = r_alu_valid;
    assign err_illegal = r_err_illegal;
    assign alu_opcode  = r_mem_opcode[r_rd_ptr];
    assign alu_a       = r_mem_a[r_rd_ptr];
    assign alu_b       = r_mem_b[r_rd_ptr];
    assign alu_shamt   = r_mem_shamt[r_rd_ptr];

`ifdef ALU_CMD_ENC_ERRCNT_EN
    logic [7:0] r_err_count;

    // Count illegal commands, holding at 255 once saturated
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_err_count <= 8'd0;
        end else if (w_accept && !w_legal && (r_err_count != 8'hFF)) begin
            r_err_count <= r_err_count + 8'd1;
        end
    end

    assign err_count = r_err_count;
`endif

endmodule

// File: tb/tb_alu_cmd_encoder.sv
// Scoreboard bench for alu_cmd_encoder: stimulus pushes expected ALU
// commands into a queue, a negedge monitor pops and compares every issue.
`timescale 1ns/1ps
module tb_alu_cmd_encoder;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [5:0]  req_onehot = 6'b000000;
    logic [31:0] req_a = 32'd0;
    logic [31:0] req_b = 32'd0;
    logic [4:0]  req_shamt = 5'd0;
    logic        alu_valid;
    logic        alu_ready = 1'b0;
    logic [4:0]  alu_opcode;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [4:0]  alu_shamt;
    logic        err_illegal;
`ifdef ALU_CMD_ENC_ERRCNT_EN
    logic [7:0]  err_count;
`endif

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  sh;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   tests = 0;
    int   fails = 0;
    int   err_exp = 0;
    int   err_seen = 0;

    alu_cmd_encoder #(.DATA_W(32), .DEPTH(2)) dut (
        .clock       (clock),
        .resetn      (resetn),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_onehot  (req_onehot),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_shamt   (req_shamt),
        .alu_valid   (alu_valid),
        .alu_ready   (alu_ready),
        .alu_opcode  (alu_opcode),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_shamt   (alu_shamt),
`ifdef ALU_CMD_ENC_ERRCNT_EN
        .err_count   (err_count),
`endif
        .err_illegal (err_illegal)
    );

    always #5 clock = ~clock;

    function automatic logic [4:0] exp_opcode(input logic [5:0] oh);
        case (oh)
            6'b000001: return 5'b00000;
            6'b000010: return 5'b00001;
            6'b000100: return 5'b00010;
            6'b001000: return 5'b00011;
            6'b010000: return 5'b00100;
            6'b100000: return 5'b00101;
            default:   return 5'b11111;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Present a command and hold it until accepted; queue the expectation
    task automatic send(input logic [5:0] oh, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] sh);
        exp_t e;
        int   n;
        req_valid  = 1'b1;
        req_onehot = oh;
        req_a      = a;
        req_b      = b;
        req_shamt  = sh;
        n = 0;
        @(negedge clock);
        while (!req_ready) begin
            n++;
            if (n > 50) begin
                tests++;
                fails++;
                $display("FAIL send_timeout: req_ready stayed 0 for onehot %b", oh);
                req_valid = 1'b0;
                return;
            end
            @(negedge clock);
        end
        if ($countones(oh) == 1) begin
            e.op = exp_opcode(oh);
            e.a  = a;
            e.b  = b;
            e.sh = sh;
            exp_q.push_back(e);
        end else begin
            err_exp++;
        end
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        req_valid  = 1'b0;
        req_onehot = 6'b000000;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clock);
            n++;
        end
        #1;
        check("drain_empty", exp_q.size(), 32'd0);
    endtask

    // Monitor: every issued command must match the oldest expectation
    always @(negedge clock) begin
        if (resetn && alu_valid && alu_ready) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_issue: opcode %b issued, no command expected", alu_opcode);
            end else begin
                mon_e = exp_q.pop_front();
                check("sb_opcode", {27'd0, alu_opcode}, {27'd0, mon_e.op});
                check("sb_a", alu_a, mon_e.a);
                check("sb_b", alu_b, mon_e.b);
                check("sb_shamt", {27'd0, alu_shamt}, {27'd0, mon_e.sh});
            end
        end
        if (err_illegal) err_seen++;
    end

    initial begin
        logic [5:0] oh;

        // Reset state
        repeat (2) @(negedge clock);
        check("rst_alu_valid", {31'd0, alu_valid}, 32'd0);
        check("rst_err", {31'd0, err_illegal}, 32'd0);
        resetn = 1'b1;
        @(negedge clock);
        check("rel_req_ready", {31'd0, req_ready}, 32'd1);
        check("rel_alu_valid", {31'd0, alu_valid}, 32'd0);
        @(posedge clock);
        #1;

        // Single SUB, one-cycle latency
        alu_ready = 1'b1;
        send(6'b000010, 32'd5, 32'd3, 5'd0);
        idle();
        check("lat_alu_valid", {31'd0, alu_valid}, 32'd1);
        check("lat_opcode", {27'd0, alu_opcode}, 32'h1);
        cycles(2);
        check("post_pop_valid", {31'd0, alu_valid}, 32'd0);

        // Backpressure: fill with ADD, OR; third request waits
        alu_ready = 1'b0;
        send(6'b000001, 32'd1, 32'd2, 5'd0);
        send(6'b001000, 32'd3, 32'd4, 5'd0);
        idle();
        check("full_req_ready", {31'd0, req_ready}, 32'd0);
        req_valid  = 1'b1;
        req_onehot = 6'b000100;
        req_a      = 32'd7;
        req_b      = 32'd8;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("hold_opcode", {27'd0, alu_opcode}, 32'h0);
            check("hold_a", alu_a, 32'd1);
            check("hold_b", alu_b, 32'd2);
            check("hold_ready", {31'd0, req_ready}, 32'd0);
        end
        @(posedge clock);
        #1;
        alu_ready = 1'b1;
        send(6'b000100, 32'd7, 32'd8, 5'd0);
        idle();
        drain();

        // Illegal commands: none set, then two set
        send(6'b000000, 32'd9, 32'd9, 5'd0);
        send(6'b010001, 32'd9, 32'd9, 5'd0);
        idle();
        cycles(3);
        check("err_pulses", err_seen, 32'd2);
        check("err_no_valid", {31'd0, alu_valid}, 32'd0);
`ifdef ALU_CMD_ENC_ERRCNT_EN
        check("err_count", {24'd0, err_count}, 32'd2);
`endif

        // Full buffer then 10 back-to-back commands with continuous pops
        alu_ready = 1'b0;
        send(6'b000001, 32'd10, 32'd11, 5'd1);
        send(6'b000010, 32'd20, 32'd21, 5'd2);
        alu_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            oh = 6'b000001;
            oh = oh << (i % 6);
            send(oh, 32'd100 + 32'(i), 32'd200 + 32'(i), 5'(i));
        end
        idle();
        drain();

        // Reset with two commands buffered
        alu_ready = 1'b0;
        send(6'b000001, 32'd1, 32'd1, 5'd0);
        send(6'b000010, 32'd2, 32'd2, 5'd0);
        idle();
        check("pre_rst_valid", {31'd0, alu_valid}, 32'd1);
        #2;
        resetn = 1'b0;
        #1;
        check("async_rst_valid", {31'd0, alu_valid}, 32'd0);
        exp_q.delete();
`ifdef ALU_CMD_ENC_ERRCNT_EN
        check("rst_err_count", {24'd0, err_count}, 32'd0);
`endif
        @(negedge clock);
        @(negedge clock);
        resetn = 1'b1;
        @(posedge clock);
        #1;
        check("rel2_alu_valid", {31'd0, alu_valid}, 32'd0);
        check("rel2_req_ready", {31'd0, req_ready}, 32'd1);
        alu_ready = 1'b1;
        cycles(4);
        check("no_stale_valid", {31'd0, alu_valid}, 32'd0);

        // Shift boundaries
        send(6'b010000, 32'h8000_0001, 32'd0, 5'd31);
        send(6'b100000, 32'hF000_0000, 32'd0, 5'd0);
        idle();
        drain();

        cycles(2);
        check("err_total", err_seen, 32'(err_exp));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
